// File: rtl/csr_file.sv
// LoongArch CSR file: exception, timer and LL/SC CSRs; updates land at the next clk edge, read port is combinational.
// No backpressure: one write, exception or ERTN is accepted every cycle, with exception > ERTN > write.
module csr_file #(
  parameter logic [31:0] TID_INIT       = 32'h0,
  parameter int          CSR_ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      csr_write_en,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_write_addr,
  input  logic [31:0]               csr_write_data,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_read_addr,
  output logic [31:0]               csr_read_data,
  input  logic                      is_exception,
  input  logic [31:0]               exception_pc,
  input  logic [31:0]               exception_addr,
  input  logic [5:0]                ecode,
  input  logic [8:0]                esubcode,
  input  logic                      is_ertn,
  input  logic                      is_llw_scw,
  input  logic                      llbit_data,
  input  logic [7:0]                hw_int,
  input  logic                      ipi,
  output logic [31:0]               crmd,
  output logic [31:0]               ecfg,
  output logic [31:0]               estat,
  output logic [31:0]               era,
  output logic [31:0]               eentry,
  output logic                      llbit
);

  localparam logic [CSR_ADDR_WIDTH-1:0] A_CRMD   = CSR_ADDR_WIDTH'('h00);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_PRMD   = CSR_ADDR_WIDTH'('h01);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_ECFG   = CSR_ADDR_WIDTH'('h04);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_ESTAT  = CSR_ADDR_WIDTH'('h05);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_ERA    = CSR_ADDR_WIDTH'('h06);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_BADV   = CSR_ADDR_WIDTH'('h07);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_EENTRY = CSR_ADDR_WIDTH'('h0c);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_SAVE0  = CSR_ADDR_WIDTH'('h30);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_SAVE1  = CSR_ADDR_WIDTH'('h31);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_SAVE2  = CSR_ADDR_WIDTH'('h32);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_SAVE3  = CSR_ADDR_WIDTH'('h33);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_TID    = CSR_ADDR_WIDTH'('h40);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_TCFG   = CSR_ADDR_WIDTH'('h41);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_TVAL   = CSR_ADDR_WIDTH'('h42);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_TICLR  = CSR_ADDR_WIDTH'('h44);
  localparam logic [CSR_ADDR_WIDTH-1:0] A_LLBCTL = CSR_ADDR_WIDTH'('h60);

  logic [8:0]  crmd_q;
  logic [2:0]  prmd_q;
  logic [12:0] ecfg_q;
  logic [1:0]  estat_sw_q;
  logic        estat_ti_q;
  logic [5:0]  estat_ecode_q;
  logic [8:0]  estat_esub_q;
  logic [31:0] era_q;
  logic [31:0] badv_q;
  logic [25:0] eentry_q;
  logic [31:0] save_q [4];
  logic [31:0] tid_q;
  logic [31:0] tcfg_q;
  logic [31:0] tval_q;
  logic        armed_q;
  logic        klo_q;
  logic        llbit_q;

  logic [31:0] wd;
  logic        exc, ertn;
  logic        badv_from_pc, badv_from_addr;
  logic        expire;
  logic        wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry;
  logic        wr_tid, wr_tcfg, wr_ticlr, wr_llbctl;
  logic [3:0]  wr_save;

  assign wd             = csr_write_data;
  assign exc            = is_exception;
  assign ertn           = is_ertn && !is_exception;
  assign badv_from_pc   = exc && (ecode == 6'h8) && (esubcode == 9'h0);
  assign badv_from_addr = exc && ((ecode == 6'h9) || ((ecode == 6'h8) && (esubcode == 9'h1)));
  assign expire         = tcfg_q[0] && armed_q && (tval_q == 32'h0);

  // Writes are dropped only for registers the winning event also modifies.
  assign wr_crmd   = csr_write_en && (csr_write_addr == A_CRMD) && !exc && !ertn;
  assign wr_prmd   = csr_write_en && (csr_write_addr == A_PRMD) && !exc;
  assign wr_ecfg   = csr_write_en && (csr_write_addr == A_ECFG);
  assign wr_estat  = csr_write_en && (csr_write_addr == A_ESTAT) && !exc;
  assign wr_era    = csr_write_en && (csr_write_addr == A_ERA) && !exc;
  assign wr_badv   = csr_write_en && (csr_write_addr == A_BADV) && !badv_from_pc && !badv_from_addr;
  assign wr_eentry = csr_write_en && (csr_write_addr == A_EENTRY);
  assign wr_tid    = csr_write_en && (csr_write_addr == A_TID);
  assign wr_tcfg   = csr_write_en && (csr_write_addr == A_TCFG);
  assign wr_ticlr  = csr_write_en && (csr_write_addr == A_TICLR);
  assign wr_llbctl = csr_write_en && (csr_write_addr == A_LLBCTL) && !ertn;
  assign wr_save[0] = csr_write_en && (csr_write_addr == A_SAVE0);
  assign wr_save[1] = csr_write_en && (csr_write_addr == A_SAVE1);
  assign wr_save[2] = csr_write_en && (csr_write_addr == A_SAVE2);
  assign wr_save[3] = csr_write_en && (csr_write_addr == A_SAVE3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crmd_q        <= 9'h008;
      prmd_q        <= '0;
      ecfg_q        <= '0;
      estat_sw_q    <= '0;
      estat_ti_q    <= 1'b0;
      estat_ecode_q <= '0;
      estat_esub_q  <= '0;
      era_q         <= '0;
      badv_q        <= '0;
      eentry_q      <= '0;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
      tid_q         <= TID_INIT;
      tcfg_q        <= '0;
      tval_q        <= '0;
      armed_q       <= 1'b0;
      klo_q         <= 1'b0;
      llbit_q       <= 1'b0;
    end else begin
      if (exc) begin
        prmd_q        <= crmd_q[2:0];
        crmd_q[2:0]   <= 3'b000;
        era_q         <= exception_pc;
        estat_ecode_q <= ecode;
        estat_esub_q  <= esubcode;
      end else if (ertn) begin
        crmd_q[2:0] <= prmd_q;
      end
      if (wr_crmd)  crmd_q     <= wd[8:0];
      if (wr_prmd)  prmd_q     <= wd[2:0];
      if (wr_ecfg)  ecfg_q     <= wd[12:0] & 13'h1bff;
      if (wr_estat) estat_sw_q <= wd[1:0];
      if (wr_era)   era_q      <= wd;

      if (badv_from_pc)        badv_q <= exception_pc;
      else if (badv_from_addr) badv_q <= exception_addr;
      else if (wr_badv)        badv_q <= wd;

      if (wr_eentry) eentry_q <= wd[31:6];
      for (int i = 0; i < 4; i++) if (wr_save[i]) save_q[i] <= wd;
      if (wr_tid) tid_q <= wd;

      if (wr_tcfg) begin
        tcfg_q  <= wd;
        tval_q  <= {wd[31:2], 2'b00};
        armed_q <= wd[0];
      end else if (tcfg_q[0] && armed_q) begin
        if (tval_q != 32'h0)  tval_q  <= tval_q - 32'd1;
        else if (tcfg_q[1])   tval_q  <= {tcfg_q[31:2], 2'b00};
        else                  armed_q <= 1'b0;
      end

      if (expire)                  estat_ti_q <= 1'b1;
      else if (wr_ticlr && wd[0])  estat_ti_q <= 1'b0;

      if (ertn)           klo_q <= 1'b0;
      else if (wr_llbctl) klo_q <= wd[2];

      if (wr_llbctl && wd[1])  llbit_q <= 1'b0;
      else if (ertn && !klo_q) llbit_q <= 1'b0;
      else if (is_llw_scw)     llbit_q <= llbit_data;
    end
  end

  assign crmd   = {23'h0, crmd_q};
  assign ecfg   = {19'h0, ecfg_q};
  assign estat  = {1'b0, estat_esub_q, estat_ecode_q, 3'b000, ipi, estat_ti_q, 1'b0, hw_int, estat_sw_q};
  assign era    = era_q;
  assign eentry = {eentry_q, 6'h00};
  assign llbit  = llbit_q;

  always_comb begin
    csr_read_data = 32'h0;
    case (csr_read_addr)
      A_CRMD:   csr_read_data = crmd;
      A_PRMD:   csr_read_data = {29'h0, prmd_q};
      A_ECFG:   csr_read_data = ecfg;
      A_ESTAT:  csr_read_data = estat;
      A_ERA:    csr_read_data = era_q;
      A_BADV:   csr_read_data = badv_q;
      A_EENTRY: csr_read_data = eentry;
      A_SAVE0:  csr_read_data = save_q[0];
      A_SAVE1:  csr_read_data = save_q[1];
      A_SAVE2:  csr_read_data = save_q[2];
      A_SAVE3:  csr_read_data = save_q[3];
      A_TID:    csr_read_data = tid_q;
      A_TCFG:   csr_read_data = tcfg_q;
      A_TVAL:   csr_read_data = tval_q;
      A_LLBCTL: csr_read_data = {29'h0, klo_q, 1'b0, llbit_q};
      default:  csr_read_data = 32'h0;
    endcase
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Control/status register file: the responder end of the commit controller's CSR interface.
- Holds the LoongArch exception, timer and LL/SC CSRs.
- Accepts one CSR write per cycle from commit, plus exception entry and ERTN return events.
- Supplies CRMD/ECFG/ESTAT/ERA/EENTRY back to the controller for interrupt detection and redirect PC, and serves a combinational read port to the dispatch stage.

Parameters:
- TID_INIT, 32'h0, reset value of TID.
- CSR_ADDR_WIDTH, 14, width of CSR address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- csr_write_en  in  1  commit write strobe.
- csr_write_addr  in  14  write address.
- csr_write_data  in  32  write data.
- csr_read_addr  in  14  read address.
- csr_read_data  out  32  read data, combinational.
- is_exception  in  1  exception entry this cycle.
- exception_pc  in  32  PC of the faulting instruction.
- exception_addr  in  32  faulting memory address.
- ecode  in  6  exception code.
- esubcode  in  9  exception subcode.
- is_ertn  in  1  ERTN commit this cycle.
- is_llw_scw  in  1  LL/SC LLBit update strobe.
- llbit_data  in  1  LLBit value on is_llw_scw.
- hw_int  in  8  hardware interrupt lines.
- ipi  in  1  inter-processor interrupt.
- crmd  out  32  CRMD.
- ecfg  out  32  ECFG.
- estat  out  32  ESTAT.
- era  out  32  ERA.
- eentry  out  32  EENTRY.
- llbit  out  1  current LLBit.

Behaviour:
- Address map, with writable bits:
  - CRMD 0x0, bits [8:0], reset 0x8 (DA=1).
  - PRMD 0x1, bits [2:0].
  - ECFG 0x4, mask 0x1BFF.
  - ESTAT 0x5: SW bits [1:0] writable; [9:2]=hw_int; [11]=TI; [12]=ipi; [21:16]=Ecode; [30:22]=EsubCode.
  - ERA 0x6, all bits.
  - BADV 0x7, all bits.
  - EENTRY 0xC, bits [31:6].
  - SAVE0-3 0x30-0x33, all bits.
  - TID 0x40, all bits.
  - TCFG 0x41: bit0 En, bit1 Periodic, [31:2] InitVal.
  - TVAL 0x42, read-only.
  - TICLR 0x44, reads 0.
  - LLBCTL 0x60: bit0 ROLLB (read = llbit), bit1 WCLLB (write-1 clears llbit, reads 0), bit2 KLO.
- Unmapped addresses: read 0, writes ignored.
- Reset: all registers 0 except CRMD=0x8 and TID=TID_INIT; llbit=0; timer halted; all outputs reflect these values.
- All updates take effect at the rising clk edge.
- csr_read_data decodes the current register state with no write bypass.
- Same-cycle priority: is_exception > is_ertn > csr_write_en. A lower-priority CSR write is dropped only if it targets a register the higher-priority event modifies.
- Exception entry:
  - PRMD.PPLV<=CRMD.PLV; PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0; CRMD.IE<=0.
  - ERA<=exception_pc.
  - ESTAT.Ecode<=ecode; ESTAT.EsubCode<=esubcode.
  - BADV<=exception_pc if ecode=0x8 and esubcode=0 (ADEF).
  - BADV<=exception_addr if ecode=0x9, or ecode=0x8 and esubcode=1.
  - BADV unchanged otherwise.
- ERTN:
  - CRMD.PLV<=PRMD.PPLV; CRMD.IE<=PRMD.PIE.
  - If LLBCTL.KLO=0, llbit<=0.
  - KLO<=0.
- is_llw_scw: llbit<=llbit_data. An LLBCTL write with WCLLB=1 in the same cycle wins (clears llbit).
- Timer:
  - A write to TCFG loads TVAL<={wdata[31:2],2'b00} and arms the timer with En=wdata[0].
  - Each cycle with En and armed: if TVAL!=0, TVAL<=TVAL-1.
  - When TVAL==0: set ESTAT.TI. If Periodic, reload {InitVal,2'b00}; otherwise disarm, TVAL holds 0, and no further TI occurs until the next TCFG write.
  - TICLR write with bit0=1 clears TI. Expiry in the same cycle wins: TI stays 1.
  - TCFG write in the same cycle as expiry: TVAL takes the written value and TI is still set.
- hw_int and ipi are sampled into ESTAT every cycle and are not latched.
- Mid-operation reset returns every register to its reset value immediately and asynchronously.

Test Plan:
- Reset, then read CRMD/ESTAT/TVAL -> 0x8/0x0/0x0; llbit=0.
- With CRMD=0x7, is_exception, ecode=0x9, exception_pc=0x1c000100, exception_addr=0x1003 -> PRMD=0x7, CRMD=0x0, ERA=0x1c000100, BADV=0x1003, ESTAT[21:16]=0x9.
- ERTN after that exception -> CRMD[2:0]=0x7. With KLO=0 and llbit=1 -> llbit=0.
- Write TCFG=0x0000000B (InitVal=2, periodic, En) -> TVAL counts 8,7,..,0; TI=1 on the cycle TVAL=0 is seen; TVAL reloads to 8. TICLR=1 in an expiry cycle -> TI remains 1.
- Write TCFG=0x9 (non-periodic, InitVal=2) -> one TI, TVAL holds 0. Clear TI via TICLR -> TI stays 0 for 20 cycles.
- Same cycle: is_exception plus csr_write_en to ERA=0xdead -> ERA=exception_pc. Write EENTRY=0xffffffff -> reads 0xffffffc0.
